// File: rtl/rs232_uart_param.sv
// Parametrised full-duplex RS232 UART: shared oversampling tick divider,
// valid/ready transmitter and mid-bit sampling receiver with parity/frame flags.
module rs232_uart_param #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY     = 2,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_parity_err,
  output logic              rx_frame_err
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick;
  logic [OS_W-1:0]   tx_os_q, tx_os_d;
  logic              bit_stb;
  state_e            tx_state_q, tx_state_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              tx_par_q, tx_par_d;
  logic              tx_started_q, tx_started_d;
  logic [3:0]        tx_cnt_q, tx_cnt_d;
  logic              tx_q, tx_d;

  logic              rx_s1_q, rx_s2_q, rx_prev_q;
  logic              rx_fall;
  state_e            rx_state_q, rx_state_d;
  logic [OS_W-1:0]   rx_os_q, rx_os_d;
  logic [3:0]        rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic              rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
  logic              rx_done_q, rx_done_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_perr_out_q, rx_perr_out_d, rx_ferr_out_q, rx_ferr_out_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q         <= '0;
      tx_os_q       <= '0;
      tx_state_q    <= S_IDLE;
      tx_sh_q       <= '0;
      tx_par_q      <= 1'b0;
      tx_started_q  <= 1'b0;
      tx_cnt_q      <= '0;
      tx_q          <= 1'b1;
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= S_IDLE;
      rx_os_q       <= '0;
      rx_cnt_q      <= '0;
      rx_sh_q       <= '0;
      rx_perr_q     <= 1'b0;
      rx_ferr_q     <= 1'b0;
      rx_done_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_perr_out_q <= 1'b0;
      rx_ferr_out_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      tx_os_q       <= tx_os_d;
      tx_state_q    <= tx_state_d;
      tx_sh_q       <= tx_sh_d;
      tx_par_q      <= tx_par_d;
      tx_started_q  <= tx_started_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_q          <= tx_d;
      rx_s1_q       <= rx;
      rx_s2_q       <= rx_s1_q;
      rx_prev_q     <= rx_s2_q;
      rx_state_q    <= rx_state_d;
      rx_os_q       <= rx_os_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_sh_q       <= rx_sh_d;
      rx_perr_q     <= rx_perr_d;
      rx_ferr_q     <= rx_ferr_d;
      rx_done_q     <= rx_done_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_perr_out_q <= rx_perr_out_d;
      rx_ferr_out_q <= rx_ferr_out_d;
    end
  end

  // Free-running tx phase counter: bit boundaries fall on its wrap.
  always_comb begin
    tick    = (div_q == DIV_LAST);
    div_d   = tick ? '0 : div_q + 1'b1;
    bit_stb = tick && (tx_os_q == OS_LAST);
    tx_os_d = tx_os_q;
    if (tick) tx_os_d = (tx_os_q == OS_LAST) ? '0 : tx_os_q + 1'b1;
  end

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_sh_d      = tx_sh_q;
    tx_par_d     = tx_par_q;
    tx_started_d = tx_started_q;
    tx_cnt_d     = tx_cnt_q;
    case (tx_state_q)
      S_IDLE: if (tx_valid) begin
        tx_sh_d      = tx_data;
        tx_par_d     = (^tx_data) ^ ODD;
        tx_started_d = 1'b0;
        tx_state_d   = S_START;
      end
      // The start bit only begins on the first boundary after acceptance.
      S_START: if (bit_stb) begin
        if (!tx_started_q) tx_started_d = 1'b1;
        else begin
          tx_cnt_d   = '0;
          tx_state_d = S_DATA;
        end
      end
      S_DATA: if (bit_stb) begin
        if (MSB_FIRST != 0) tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
        else                tx_sh_d = {1'b0, tx_sh_q[DATA_W-1:1]};
        if (tx_cnt_q == DATA_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end else tx_cnt_d = tx_cnt_q + 4'd1;
      end
      S_PAR: if (bit_stb) begin
        tx_cnt_d   = '0;
        tx_state_d = S_STOP;
      end
      S_STOP: if (bit_stb) begin
        if (tx_cnt_q == STOP_LAST) tx_state_d = S_IDLE;
        else                       tx_cnt_d   = tx_cnt_q + 4'd1;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // Line level is registered from next-state values, so it has no lag or glitches.
  always_comb begin
    tx_ready = (tx_state_q == S_IDLE);
    tx_busy  = (tx_state_q != S_IDLE);
    tx       = tx_q;
    case (tx_state_d)
      S_START: tx_d = ~tx_started_d;
      S_DATA:  tx_d = (MSB_FIRST != 0) ? tx_sh_d[DATA_W-1] : tx_sh_d[0];
      S_PAR:   tx_d = tx_par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    rx_fall    = rx_prev_q & ~rx_s2_q;
    rx_state_d = rx_state_q;
    rx_os_d    = rx_os_q;
    rx_cnt_d   = rx_cnt_q;
    rx_sh_d    = rx_sh_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_done_d  = 1'b0;
    case (rx_state_q)
      S_IDLE: if (rx_fall) begin
        rx_os_d    = '0;
        rx_perr_d  = 1'b0;
        rx_ferr_d  = 1'b0;
        rx_state_d = S_START;
      end
      // Half-bit check rejects glitches and realigns sampling to mid-bit.
      S_START: if (tick) begin
        if (rx_os_q == OS_MID) begin
          rx_os_d  = '0;
          rx_cnt_d = '0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else rx_os_d = rx_os_q + 1'b1;
      end
      S_DATA: if (tick) begin
        if (rx_os_q == OS_LAST) begin
          rx_os_d = '0;
          if (MSB_FIRST != 0) rx_sh_d = {rx_sh_q[DATA_W-2:0], rx_s2_q};
          else                rx_sh_d = {rx_s2_q, rx_sh_q[DATA_W-1:1]};
          if (rx_cnt_q == DATA_LAST) begin
            rx_cnt_d   = '0;
            rx_state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else rx_cnt_d = rx_cnt_q + 4'd1;
        end else rx_os_d = rx_os_q + 1'b1;
      end
      S_PAR: if (tick) begin
        if (rx_os_q == OS_LAST) begin
          rx_os_d    = '0;
          rx_perr_d  = rx_s2_q != ((^rx_sh_q) ^ ODD);
          rx_cnt_d   = '0;
          rx_state_d = S_STOP;
        end else rx_os_d = rx_os_q + 1'b1;
      end
      S_STOP: if (tick) begin
        if (rx_os_q == OS_LAST) begin
          rx_os_d = '0;
          if (!rx_s2_q) rx_ferr_d = 1'b1;
          if (rx_cnt_q == STOP_LAST) begin
            rx_done_d  = 1'b1;
            rx_state_d = S_IDLE;
          end else rx_cnt_d = rx_cnt_q + 4'd1;
        end else rx_os_d = rx_os_q + 1'b1;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_valid_d    = rx_done_q;
    rx_data_d     = rx_done_q ? rx_sh_q   : rx_data_q;
    rx_perr_out_d = rx_done_q ? rx_perr_q : rx_perr_out_q;
    rx_ferr_out_d = rx_done_q ? rx_ferr_q : rx_ferr_out_q;
    rx_data       = rx_data_q;
    rx_valid      = rx_valid_q;
    rx_parity_err = rx_perr_out_q;
    rx_frame_err  = rx_ferr_out_q;
  end

endmodule

// File: tb/tb_rs232_uart_param.sv
// Directed bench for rs232_uart_param: an 8O1 MSB-first instance driven from the bench
// and a 7E2 LSB-first instance in tx->rx loopback, both at 64 clocks per bit.
module tb_rs232_uart_param;

  localparam int unsigned CLKF = 614400;  // 9600 * 16 * 4 -> DIV = 4
  localparam int BIT = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tx_data0, rx_data0;
  logic       tx_valid0, tx_ready0, tx_busy0, tx0, rx0, rx_valid0, perr0, ferr0;
  logic [6:0] tx_data1, rx_data1;
  logic       tx_valid1, tx_ready1, tx_busy1, tx1, rx_valid1, perr1, ferr1;

  rs232_uart_param #(.CLK_FREQ(CLKF), .BAUD(9600), .OVERSAMPLE(16), .DATA_W(8),
                     .PARITY(2), .STOP_BITS(1), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .tx_busy(tx_busy0), .tx(tx0), .rx(rx0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_parity_err(perr0), .rx_frame_err(ferr0));

  rs232_uart_param #(.CLK_FREQ(CLKF), .BAUD(9600), .OVERSAMPLE(16), .DATA_W(7),
                     .PARITY(1), .STOP_BITS(2), .MSB_FIRST(0)) u1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .tx_busy(tx_busy1), .tx(tx1), .rx(tx1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_parity_err(perr1), .rx_frame_err(ferr1));

  int total = 0;
  int bad   = 0;

  int         vcnt0 = 0, vcnt1 = 0;
  logic [7:0] ld0 = '0;
  logic [6:0] ld1 = '0;
  logic       lp0 = 1'b0, lf0 = 1'b0, lp1 = 1'b0, lf1 = 1'b0;

  // Each high cycle of rx_valid is counted, so a stretched pulse shows up as 2.
  always @(negedge clk) begin
    if (rx_valid0 === 1'b1) begin
      vcnt0 <= vcnt0 + 1;
      ld0 <= rx_data0; lp0 <= perr0; lf0 <= ferr0;
    end
    if (rx_valid1 === 1'b1) begin
      vcnt1 <= vcnt1 + 1;
      ld1 <= rx_data1; lp1 <= perr1; lf1 <= ferr1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start, 8 data bits MSB first, odd parity (optionally inverted), given stop level.
  task automatic send_rx(input logic [7:0] d, input logic par_flip, input logic stop_v);
    logic [10:0] bits;
    bits = {1'b0, d, (~^d) ^ par_flip, stop_v};
    for (int i = 10; i >= 0; i--) begin
      rx0 = bits[i];
      wait_clks(BIT);
    end
    rx0 = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int v;
    int len;
    logic [10:0] eb;
    logic [7:0]  d6;

    rst = 1'b0; rx0 = 1'b1;
    tx_data0 = '0; tx_valid0 = 1'b0;
    tx_data1 = '0; tx_valid1 = 1'b0;
    wait_clks(5);
    chk("rst_tx",       tx0,       1);
    chk("rst_tx_ready", tx_ready0, 1);
    chk("rst_tx_busy",  tx_busy0,  0);
    chk("rst_rx_data",  rx_data0,  0);
    chk("rst_rx_valid", rx_valid0, 0);
    chk("rst_perr",     perr0,     0);
    chk("rst_ferr",     ferr0,     0);
    chk("rst_tx1",      tx1,       1);
    rst = 1'b1;
    wait_clks(2 * BIT);

    // 1: clean 0x0D
    v = vcnt0;
    send_rx(8'h0D, 1'b0, 1'b1);
    wait_clks(BIT);
    chk("t1_pulses", vcnt0 - v, 1);
    chk("t1_data",   ld0, 8'h0D);
    chk("t1_perr",   lp0, 0);
    chk("t1_ferr",   lf0, 0);

    // 2: 0x0B with wrong parity bit
    v = vcnt0;
    send_rx(8'h0B, 1'b1, 1'b1);
    wait_clks(BIT);
    chk("t2_pulses", vcnt0 - v, 1);
    chk("t2_data",   ld0, 8'h0B);
    chk("t2_perr",   lp0, 1);
    chk("t2_ferr",   lf0, 0);

    // 3: transmit 0x0A, second request mid-frame must be ignored
    tx_data0 = 8'h0A; tx_valid0 = 1'b1;
    wait_clks(1);
    tx_valid0 = 1'b0;
    chk("t3_ready_drop", tx_ready0, 0);
    chk("t3_busy",       tx_busy0,  1);
    for (int k = 0; k < 2 * BIT && tx0 !== 1'b0; k++) wait_clks(1);
    chk("t3_start_seen", tx0, 0);
    wait_clks(BIT / 2);
    eb = 11'b0_00001010_1_1;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("t3_bit%0d", i), tx0, eb[10-i]);
      if (i == 4) begin
        chk("t3_ready_mid", tx_ready0, 0);
        tx_data0 = 8'hFF; tx_valid0 = 1'b1;
        wait_clks(1);
        tx_valid0 = 1'b0;
        wait_clks(BIT - 1);
      end else if (i < 10) begin
        wait_clks(BIT);
      end
    end
    chk("t3_ready_in_stop", tx_ready0, 0);
    for (int k = 0; k < BIT && tx_ready0 !== 1'b1; k++) wait_clks(1);
    chk("t3_ready_back", tx_ready0, 1);
    chk("t3_idle_high",  tx0, 1);

    // 4: short glitch, then 0x55 with a low stop bit
    v = vcnt0;
    rx0 = 1'b0;
    wait_clks(2);
    rx0 = 1'b1;
    wait_clks(2 * BIT);
    chk("t4_glitch_pulses", vcnt0 - v, 0);
    send_rx(8'h55, 1'b0, 1'b0);
    wait_clks(BIT);
    chk("t4_pulses", vcnt0 - v, 1);
    chk("t4_data",   ld0, 8'h55);
    chk("t4_perr",   lp0, 0);
    chk("t4_ferr",   lf0, 1);

    // 5: 7E2 LSB-first loopback of 0x5A, 11 bit periods per frame
    v = vcnt1;
    tx_data1 = 7'h5A; tx_valid1 = 1'b1;
    wait_clks(1);
    tx_valid1 = 1'b0;
    for (int k = 0; k < 2 * BIT && tx1 !== 1'b0; k++) wait_clks(1);
    chk("t5_start_seen", tx1, 0);
    len = 0;
    while (tx_ready1 !== 1'b1 && len < 2000) begin
      wait_clks(1);
      len++;
    end
    chk("t5_frame_clks", len, 11 * BIT);
    wait_clks(BIT);
    chk("t5_pulses", vcnt1 - v, 1);
    chk("t5_data",   ld1, 7'h5A);
    chk("t5_perr",   lp1, 0);
    chk("t5_ferr",   lf1, 0);

    // 6: reset during rx data bit 4 while tx is mid-frame
    tx_data0 = 8'h3C; tx_valid0 = 1'b1;
    wait_clks(1);
    tx_valid0 = 1'b0;
    v = vcnt0;
    d6 = 8'hC3;
    rx0 = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      rx0 = d6[7-i];
      wait_clks(BIT);
    end
    rx0 = d6[3];
    wait_clks(BIT / 2);
    chk("t6_tx_busy_pre", tx_busy0, 1);
    rst = 1'b0; rx0 = 1'b1;
    wait_clks(3);
    chk("t6_tx",       tx0,       1);
    chk("t6_tx_ready", tx_ready0, 1);
    chk("t6_tx_busy",  tx_busy0,  0);
    chk("t6_rx_valid", rx_valid0, 0);
    chk("t6_rx_data",  rx_data0,  0);
    rst = 1'b1;
    wait_clks(3 * BIT);
    chk("t6_no_pulse", vcnt0 - v, 0);
    send_rx(8'hA5, 1'b0, 1'b1);
    wait_clks(BIT);
    chk("t6_pulses", vcnt0 - v, 1);
    chk("t6_data",   ld0, 8'hA5);
    chk("t6_perr",   lp0, 0);
    chk("t6_ferr",   lf0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs232_uart_param.md
Name: rs232_uart_param

Overview:
Parametrised full-duplex RS232 UART. It replaces the fixed 8-bit controller plus separate clock-enable generator with one block. The block contains:
- an internal oversampling baud divider
- a configurable word width, parity mode, stop-bit count and bit order
- a valid/ready transmit handshake
- a receive path with error flags

It sits between the board rx/tx pins and the memory-side word interface.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s
OVERSAMPLE, 16, rx sample ticks per bit; must be even and >= 8
DATA_W, 8, data bits per frame; range 5..9
PARITY, 2, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
MSB_FIRST, 1, 1 = bit DATA_W-1 sent first, 0 = LSB first

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
tx_data  input  DATA_W  word to transmit
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a word this cycle
tx_busy  output  1  frame in progress on tx
tx  output  1  serial output, idle high
rx  input  1  serial input, asynchronous to clk
rx_data  output  DATA_W  last received word, held until next frame completes
rx_valid  output  1  one-cycle pulse: rx_data updated
rx_parity_err  output  1  qualified by rx_valid: parity mismatch
rx_frame_err  output  1  qualified by rx_valid: a stop bit sampled low

Behaviour:
- Reset (rst low, async) sets: tx = 1, tx_ready = 1, tx_busy = 0, rx_data = 0, rx_valid = 0, both err = 0. Both FSMs go to IDLE and the divider goes to 0.
- Tick divider: DIV = CLK_FREQ / (BAUD * OVERSAMPLE), integer-truncated. The counter runs 0..DIV-1 continuously and produces a one-cycle tick at the wrap.
  - Bit period = DIV * OVERSAMPLE clocks. Defaults: DIV = 651, bit period = 10416 clocks.
- TX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: tx_ready = 1. When tx_valid && tx_ready, capture tx_data, drop tx_ready and raise tx_busy on the same edge.
  - START holds tx = 0 for one bit period, starting at the next OVERSAMPLE-tick boundary. Start-to-line latency is at most DIV * OVERSAMPLE clocks.
  - DATA sends DATA_W bits in the MSB_FIRST order, one bit period each.
  - PAR sends one bit only when PARITY != 0.
    - Even: XOR of the data bits.
    - Odd: inverted XOR of the data bits.
  - STOP holds tx = 1 for STOP_BITS bit periods, then returns to IDLE with tx_ready = 1.
  - tx_valid while busy is ignored; the word is not queued.
- RX path: rx passes through a 2-FF synchroniser preset to 1 on reset. All decisions use the synchronised value.
- RX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: a falling edge (sync 1 -> 0) resets the sample counter to 0. Counting is in ticks.
  - START: at OVERSAMPLE/2 ticks, re-sample.
    - If 1: false start; return to IDLE with no pulse.
    - If 0: realign the counter so later samples land mid-bit, every OVERSAMPLE ticks.
  - DATA shifts DATA_W samples into place per MSB_FIRST.
  - PAR, present only if PARITY != 0, compares the sampled bit with the expected parity and sets an internal parity flag.
  - STOP samples STOP_BITS bits mid-bit. Any 0 sets the frame flag.
  - After the last stop sample, the next clock:
    - loads rx_data;
    - drives rx_parity_err and rx_frame_err;
    - pulses rx_valid for exactly 1 cycle.
  - The FSM then returns to IDLE and rearms immediately. A low line at that point is treated as a new start edge only after it has been seen high.
  - Errored words are still delivered with the flags set.
  - With PARITY = 0, rx_parity_err is always 0.
- Simultaneous TX and RX are fully independent. Loopback (tx tied to rx) must work.
- Reset mid-frame: tx returns high within the reset assertion and any partial rx word is discarded, with no rx_valid.

Test Plan:
1. Defaults, rx frame 0,0,0,0,0,1,1,0,1,0,1 at 104160 ns/bit (0x0D MSB first, odd parity bit 0) -> one rx_valid pulse, rx_data = 8'h0D, both err = 0.
2. Defaults, rx frame 0x0B with parity bit 1 -> rx_valid, rx_data = 8'h0B, rx_parity_err = 1, rx_frame_err = 0.
3. tx_data = 8'h0A, tx_valid for 1 cycle -> tx_ready falls next edge. tx shows 0,0,0,0,0,1,0,1,0,1(parity),1, each 10416 clocks. tx_ready returns after the stop bit. A second tx_valid mid-frame is ignored.
4. 2-cycle low glitch on rx while idle -> no rx_valid and FSM back in IDLE; then the stop bit is forced low on a 0x55 frame -> rx_frame_err = 1, rx_data = 8'h55.
5. DATA_W = 7, PARITY = 1, STOP_BITS = 2, MSB_FIRST = 0, loopback tx to rx, send 7'h5A -> rx_valid with rx_data = 7'h5A, no errors. Frame length = 11 bit periods.
6. Assert rst low mid-rx (bit 4) and mid-tx -> tx = 1, tx_ready = 1, no rx_valid. The next clean frame 0xA5 is received correctly.
